// File: rtl/user_selection_controller_pkg.sv
// rtl/user_selection_controller_pkg.sv - shared types, defaults and init-geometry check
package user_sel_pkg;

  typedef enum logic [1:0] {
    EDIT   = 2'd0,
    COMMIT = 2'd1,
    LOCKED = 2'd2
  } sel_state_t;

  localparam int DEF_N             = 10;
  localparam int DEF_H_ACTIVE      = 640;
  localparam int DEF_V_ACTIVE      = 480;
  localparam int DEF_STEP          = 4;
  localparam int DEF_MIN_SIZE      = 16;
  localparam int DEF_INIT_X        = 0;
  localparam int DEF_INIT_Y        = 0;
  localparam int DEF_INIT_W        = 256;
  localparam int DEF_INIT_H        = 256;
  localparam int DEF_REPEAT_FRAMES = 8;

  // Direction indices into the per-direction pending/press vectors
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  function automatic bit init_fits(input int x, input int y, input int w, input int h,
                                   input int h_act, input int v_act, input int min_size);
    return (x + w <= h_act) && (y + h <= v_act) && (w >= min_size) && (h >= min_size);
  endfunction

  localparam bit DEF_INIT_OK = init_fits(DEF_INIT_X, DEF_INIT_Y, DEF_INIT_W, DEF_INIT_H,
                                         DEF_H_ACTIVE, DEF_V_ACTIVE, DEF_MIN_SIZE);

endpackage

// File: rtl/user_selection_controller_if.sv
// rtl/user_selection_controller_if.sv - board controls in, selection rectangle out
interface user_sel_if #(
  parameter int N = 10
) ();
  logic         btn_up;
  logic         btn_down;
  logic         btn_left;
  logic         btn_right;
  logic         mode_resize;
  logic         btn_confirm;
  logic [N-1:0] x_pos;
  logic [N-1:0] y_pos;
  logic [N-1:0] width;
  logic [N-1:0] height;
  logic         locked;
  logic         box_updated;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, mode_resize, btn_confirm,
    input  x_pos, y_pos, width, height, locked, box_updated
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, mode_resize, btn_confirm,
    output x_pos, y_pos, width, height, locked, box_updated
  );
endinterface

// File: rtl/user_selection_controller_button_conditioner.sv
// rtl/user_selection_controller_button_conditioner.sv - 2-flop sync, press edge, frame-based auto-repeat
module button_conditioner #(
  parameter int REPEAT_FRAMES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic frame_tick,
  input  logic enable,
  output logic press,
  output logic rep
);

  localparam int CW = (REPEAT_FRAMES < 2) ? 1 : $clog2(REPEAT_FRAMES + 1);
  localparam logic [CW-1:0] REP_AT = CW'(REPEAT_FRAMES - 1);

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Counts frame ticks while held; saturates once auto-repeat is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || !sync2) begin
      cnt <= '0;
    end else if (frame_tick && (cnt < REP_AT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign press = enable & sync2 & ~prev;
  assign rep   = enable & sync2 & frame_tick & (cnt >= REP_AT);

endmodule

// File: rtl/user_selection_controller.sv
// rtl/user_selection_controller.sv - selection rectangle owner: vblank-aligned edits, commit/lock FSM
module user_selection_controller
  import user_sel_pkg::*;
#(
  parameter int N             = DEF_N,
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int STEP          = DEF_STEP,
  parameter int MIN_SIZE      = DEF_MIN_SIZE,
  parameter int INIT_X        = DEF_INIT_X,
  parameter int INIT_Y        = DEF_INIT_Y,
  parameter int INIT_W        = DEF_INIT_W,
  parameter int INIT_H        = DEF_INIT_H,
  parameter int REPEAT_FRAMES = DEF_REPEAT_FRAMES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] h_count,
  input  logic [N-1:0] v_count,
  user_sel_if.slave    sel
);

  if (!init_fits(INIT_X, INIT_Y, INIT_W, INIT_H, H_ACTIVE, V_ACTIVE, MIN_SIZE)) begin : g_init_check
    $error("INIT_* rectangle does not fit the active area");
  end

  localparam logic [N:0] STEP_W   = (N+1)'(STEP);
  localparam logic [N:0] MIN_W    = (N+1)'(MIN_SIZE);
  localparam logic [N:0] MIN_STEP = (N+1)'(MIN_SIZE + STEP);
  localparam logic [N:0] H_LIM    = (N+1)'(H_ACTIVE);
  localparam logic [N:0] V_LIM    = (N+1)'(V_ACTIVE);

  sel_state_t   state_q, state_d;
  logic         tick_q;
  logic         mode_s1, mode_s2;
  logic [3:0]   dir_raw, dir_press, dir_rep, pend_q, req;
  logic         dir_en;
  logic         confirm_press, unused_confirm_rep;
  logic         apply;
  logic [N-1:0] x_q, y_q, w_q, h_q;
  logic [N-1:0] x_nx, y_nx, w_nx, h_nx;
  logic         changed, upd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= 1'b0;
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
    end else begin
      tick_q  <= (v_count == N'(V_ACTIVE)) && (h_count == '0);
      mode_s1 <= sel.mode_resize;
      mode_s2 <= mode_s1;
    end
  end

  assign dir_raw = {sel.btn_right, sel.btn_left, sel.btn_down, sel.btn_up};
  assign dir_en  = (state_q != LOCKED);

  for (genvar i = 0; i < 4; i++) begin : g_dir
    button_conditioner #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_cond (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (dir_raw[i]),
      .frame_tick(tick_q),
      .enable    (dir_en),
      .press     (dir_press[i]),
      .rep       (dir_rep[i])
    );
  end

  button_conditioner #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_confirm (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (sel.btn_confirm),
    .frame_tick(tick_q),
    .enable    (1'b1),
    .press     (confirm_press),
    .rep       (unused_confirm_rep)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (tick_q || (state_q == LOCKED)) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_q | dir_press;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EDIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    unique case (state_q)
      EDIT: begin
        apply = tick_q;
        if (confirm_press) state_d = COMMIT;
      end
      COMMIT: begin
        if (tick_q) begin
          apply   = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (confirm_press) state_d = EDIT;
      end
      default: state_d = EDIT;
    endcase
  end

  // One axis: inc/dec move the corner in move mode, grow/shrink the size in resize mode
  function automatic logic [2*N-1:0] axis_next(input logic [N-1:0] pos, input logic [N-1:0] size,
                                               input logic inc, input logic dec,
                                               input logic resize, input logic [N:0] limit);
    logic [N:0]   p, s;
    logic [N-1:0] np, ns;
    p  = {1'b0, pos};
    s  = {1'b0, size};
    np = pos;
    ns = size;
    if (inc && !dec) begin
      if (!resize) np = ((p + STEP_W) > (limit - s)) ? N'(limit - s) : N'(p + STEP_W);
      else         ns = ((s + STEP_W) > (limit - p)) ? N'(limit - p) : N'(s + STEP_W);
    end else if (dec && !inc) begin
      if (!resize) np = (p >= STEP_W) ? N'(p - STEP_W) : '0;
      else         ns = (s >= MIN_STEP) ? N'(s - STEP_W) : N'(MIN_W);
    end
    return {np, ns};
  endfunction

  assign req = pend_q | dir_press | dir_rep;

  always_comb begin
    {x_nx, w_nx} = axis_next(x_q, w_q, req[DIR_RIGHT], req[DIR_LEFT], mode_s2, H_LIM);
    {y_nx, h_nx} = axis_next(y_q, h_q, req[DIR_DOWN],  req[DIR_UP],   mode_s2, V_LIM);
    changed = (x_nx != x_q) || (y_nx != y_q) || (w_nx != w_q) || (h_nx != h_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= N'(INIT_X);
      y_q   <= N'(INIT_Y);
      w_q   <= N'(INIT_W);
      h_q   <= N'(INIT_H);
      upd_q <= 1'b0;
    end else begin
      upd_q <= apply && changed;
      if (apply) begin
        x_q <= x_nx;
        y_q <= y_nx;
        w_q <= w_nx;
        h_q <= h_nx;
      end
    end
  end

  assign sel.x_pos       = x_q;
  assign sel.y_pos       = y_q;
  assign sel.width       = w_q;
  assign sel.height      = h_q;
  assign sel.locked      = (state_q == LOCKED);
  assign sel.box_updated = upd_q;

endmodule
